// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush handling and saturating event counters.
// One-cycle latency ID->EX; on a load-use hazard PC and IF/ID are held for one cycle while a bubble is loaded.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_regdst,
  input  logic              id_alusrc,
  input  logic              id_branch,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_regwrite,
  input  logic              id_memtoreg,
  input  logic              id_jump,
  input  logic              id_extsel,
  input  logic [1:0]        id_aluop,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [4:0]        id_shamt,
  input  logic [5:0]        id_funct,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              flush,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ex_valid,
  output logic              ex_regdst,
  output logic              ex_alusrc,
  output logic              ex_branch,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic              ex_jump,
  output logic              ex_extsel,
  output logic [1:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [4:0]        ex_shamt,
  output logic [5:0]        ex_funct,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic id_uses_rt;
  logic hazard;
  logic bubble;
  logic load_ctrl;

  assign id_uses_rt = id_regdst | id_memwrite | id_branch;
  assign hazard     = ex_valid & ex_memread & (ex_rt != '0) & id_valid &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign pc_write   = ~(hazard & ~flush);
  assign ifid_write = ~(hazard & ~flush);
  assign bubble     = flush | hazard;
  // Gating with id_valid keeps undriven decoder bits of an empty slot out of EX.
  assign load_ctrl  = ~bubble & id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_branch   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_jump     <= 1'b0;
      ex_extsel   <= 1'b0;
      ex_aluop    <= 2'b00;
    end else begin
      ex_valid    <= load_ctrl;
      ex_regdst   <= load_ctrl & id_regdst;
      ex_alusrc   <= load_ctrl & id_alusrc;
      ex_branch   <= load_ctrl & id_branch;
      ex_memread  <= load_ctrl & id_memread;
      ex_memwrite <= load_ctrl & id_memwrite;
      ex_regwrite <= load_ctrl & id_regwrite;
      ex_memtoreg <= load_ctrl & id_memtoreg;
      ex_jump     <= load_ctrl & id_jump;
      ex_extsel   <= load_ctrl & id_extsel;
      ex_aluop    <= load_ctrl ? id_aluop : 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_shamt   <= '0;
      ex_funct   <= '0;
      ex_pc4     <= '0;
    end else begin
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_shamt   <= id_shamt;
      ex_funct   <= id_funct;
      ex_pc4     <= id_pc4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      if (id_valid && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
    end else if (hazard) begin
      if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: expected EX state is queued when a step is driven and checked after the edge.
module tb_id_ex_stage_reg;

  localparam int CW = 2;
  localparam int CMAX = 3;

  // {regdst, alusrc, branch, memread, memwrite, regwrite, memtoreg, jump, extsel, aluop[1:0]}
  localparam logic [10:0] C_LW    = 11'b0_1_0_1_0_1_1_0_1_00;
  localparam logic [10:0] C_ADD   = 11'b1_0_0_0_0_1_0_0_0_10;
  localparam logic [10:0] C_SW    = 11'b0_1_0_0_1_0_0_0_1_00;
  localparam logic [10:0] C_ADDIU = 11'b0_1_0_0_0_1_0_0_1_00;

  typedef struct {
    logic        valid;
    logic [10:0] ctrl;
    logic [31:0] rs_data, rt_data, imm, pc4;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    int          stall, flsh;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, flush;
  logic [10:0] id_ctrl;
  logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [5:0]  id_funct;
  logic pc_write, ifid_write, ex_valid;
  logic ex_regdst, ex_alusrc, ex_branch, ex_memread, ex_memwrite;
  logic ex_regwrite, ex_memtoreg, ex_jump, ex_extsel;
  logic [1:0]  ex_aluop;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [5:0]  ex_funct;
  logic [CW-1:0] stall_cnt, flush_cnt;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_regdst(id_ctrl[10]), .id_alusrc(id_ctrl[9]), .id_branch(id_ctrl[8]),
    .id_memread(id_ctrl[7]), .id_memwrite(id_ctrl[6]), .id_regwrite(id_ctrl[5]),
    .id_memtoreg(id_ctrl[4]), .id_jump(id_ctrl[3]), .id_extsel(id_ctrl[2]),
    .id_aluop(id_ctrl[1:0]),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_funct(id_funct), .id_pc4(id_pc4), .flush(flush),
    .pc_write(pc_write), .ifid_write(ifid_write), .ex_valid(ex_valid),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_jump(ex_jump), .ex_extsel(ex_extsel),
    .ex_aluop(ex_aluop),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
    .ex_funct(ex_funct), .ex_pc4(ex_pc4),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [10:0] ex_ctrl();
    return {ex_regdst, ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_regwrite,
            ex_memtoreg, ex_jump, ex_extsel, ex_aluop};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [10:0] c, input int rs, input int rt, input int rd);
    id_valid   = 1'b1;
    id_ctrl    = c;
    id_rs      = 5'(rs);
    id_rt      = 5'(rt);
    id_rd      = 5'(rd);
    id_rs_data = $urandom;
    id_rt_data = $urandom;
    id_imm     = $urandom;
    id_shamt   = 5'($urandom_range(0, 31));
    id_funct   = 6'($urandom_range(0, 63));
    id_pc4     = id_pc4 + 32'd4;
  endtask

  // Drive the current ID inputs for one edge; exp_bub says whether a bubble must be loaded.
  task automatic step(input string tag, input logic exp_pcw, input logic exp_bub);
    exp_t e;
    logic ld;
    #1;
    chk({tag, ":pc_write"}, 64'(pc_write), 64'(exp_pcw));
    chk({tag, ":ifid_write"}, 64'(ifid_write), 64'(exp_pcw));
    ld = ~exp_bub & id_valid;
    e.valid = ld;
    e.ctrl = ld ? id_ctrl : 11'd0;
    e.rs_data = id_rs_data; e.rt_data = id_rt_data; e.imm = id_imm; e.pc4 = id_pc4;
    e.rs = id_rs; e.rt = id_rt; e.rd = id_rd; e.shamt = id_shamt; e.funct = id_funct;
    if (exp_bub) begin
      if (flush) begin
        if (id_valid && m_flush < CMAX) m_flush++;
      end else if (m_stall < CMAX) m_stall++;
    end
    e.stall = m_stall;
    e.flsh = m_flush;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ":ex_valid"}, 64'(ex_valid), 64'(e.valid));
    chk({tag, ":ex_ctrl"}, 64'(ex_ctrl()), 64'(e.ctrl));
    chk({tag, ":ex_rs"}, 64'(ex_rs), 64'(e.rs));
    chk({tag, ":ex_rt"}, 64'(ex_rt), 64'(e.rt));
    chk({tag, ":ex_rd"}, 64'(ex_rd), 64'(e.rd));
    chk({tag, ":ex_data"}, {ex_rs_data, ex_rt_data}, {e.rs_data, e.rt_data});
    chk({tag, ":ex_imm_pc4"}, {ex_imm, ex_pc4}, {e.imm, e.pc4});
    chk({tag, ":ex_sh_fn"}, 64'({ex_shamt, ex_funct}), 64'({e.shamt, e.funct}));
    chk({tag, ":stall_cnt"}, 64'(stall_cnt), 64'(e.stall));
    chk({tag, ":flush_cnt"}, 64'(flush_cnt), 64'(e.flsh));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ":pc_write"}, 64'(pc_write), 64'd1);
    chk({tag, ":ex_valid"}, 64'(ex_valid), 64'd0);
    chk({tag, ":ex_ctrl"}, 64'(ex_ctrl()), 64'd0);
    chk({tag, ":ex_regs"}, 64'({ex_rs, ex_rt, ex_rd}), 64'd0);
    chk({tag, ":ex_data"}, {ex_rs_data, ex_pc4}, 64'd0);
    chk({tag, ":cnts"}, 64'({stall_cnt, flush_cnt}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; id_ctrl = '0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_pc4 = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0; id_funct = '0;
    #12;
    chk_reset_state("por");
    rst_n = 1'b1;

    // lw $5 then dependent add: one bubble, then add advances
    set_instr(C_LW, 1, 5, 0);     step("lw5", 1'b1, 1'b0);
    set_instr(C_ADD, 5, 7, 6);    step("add_stall", 1'b0, 1'b1);
    step("add_go", 1'b1, 1'b0);
    chk("add_go:rs5", 64'(ex_rs), 64'd5);

    // load into $0 never stalls
    set_instr(C_LW, 1, 0, 0);     step("lw0", 1'b1, 1'b0);
    set_instr(C_ADD, 0, 7, 6);    step("add0", 1'b1, 1'b0);

    // store data uses rt -> stall; addiu only reads rs -> no stall
    set_instr(C_LW, 2, 5, 0);     step("lw5b", 1'b1, 1'b0);
    set_instr(C_SW, 8, 5, 0);     step("sw_stall", 1'b0, 1'b1);
    step("sw_go", 1'b1, 1'b0);
    set_instr(C_LW, 2, 5, 0);     step("lw5c", 1'b1, 1'b0);
    set_instr(C_ADDIU, 9, 5, 0);  step("addiu", 1'b1, 1'b0);

    // hazard and flush together: flush wins
    set_instr(C_LW, 3, 5, 0);     step("lw5d", 1'b1, 1'b0);
    set_instr(C_ADD, 5, 7, 6);    flush = 1'b1;
    step("hz_flush", 1'b1, 1'b1);
    flush = 1'b0;
    set_instr(C_ADD, 1, 2, 3);    step("post_flush", 1'b1, 1'b0);

    // asynchronous reset while a stall is pending
    set_instr(C_LW, 1, 5, 0);     step("lw5e", 1'b1, 1'b0);
    set_instr(C_ADD, 5, 7, 6);
    #1;
    chk("pre_rst:pc_write", 64'(pc_write), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    m_stall = 0; m_flush = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_rel:pc_write", 64'(pc_write), 64'd1);

    // five stalls on a 2-bit counter: saturates at 3
    for (int i = 0; i < 5; i++) begin
      set_instr(C_LW, 1, 5, 0);   step("sat_lw", 1'b1, 1'b0);
      set_instr(C_ADD, 7, 5, 6);  step("sat_stall", 1'b0, 1'b1);
      step("sat_go", 1'b1, 1'b0);
    end
    chk("sat:stall_cnt", 64'(stall_cnt), 64'd3);

    // empty slot with all decoder bits high: control must stay zero
    set_instr(11'h7FF, 4, 4, 4);  id_valid = 1'b0;
    step("empty", 1'b1, 1'b0);
    // flush of an empty slot is not counted
    flush = 1'b1;
    step("flush_empty", 1'b1, 1'b1);
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
